// File: rtl/dec_wb_arb_if.sv
// Bundles the producer-side handshake and the three GPR write ports of dec_wb_arb.
interface dec_wb_arb_if #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC-1:0]            src_ready;
    logic [NUM_SRC*5-1:0]          src_waddr;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_wdata;

    logic                  we0, we1, we2;
    logic [4:0]            waddr0, waddr1, waddr2;
    logic [DATA_WIDTH-1:0] wd0, wd1, wd2;

    modport master (
        output src_valid, src_waddr, src_wdata,
        input  src_ready,
        input  we0, we1, we2, waddr0, waddr1, waddr2, wd0, wd1, wd2
    );

    modport slave (
        input  src_valid, src_waddr, src_wdata,
        output src_ready,
        output we0, we1, we2, waddr0, waddr1, waddr2, wd0, wd1, wd2
    );
endinterface

// File: rtl/dec_wb_arb.sv
// Writeback arbiter: per-source FIFOs feeding three registered GPR write ports with no
// same-cycle address collisions. Define DEC_WB_ARB_RR_EN for a round-robin scan start.
module dec_wb_arb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    dec_wb_arb_if.slave  bus,
    output logic         idle
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SrcW = $clog2(NUM_SRC);
    localparam int unsigned SumW = SrcW + 1;

    logic [4:0]            addr_mem_q [NUM_SRC][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [NUM_SRC][FIFO_DEPTH];
    logic [PtrW-1:0]       rd_ptr_q   [NUM_SRC];
    logic [PtrW-1:0]       wr_ptr_q   [NUM_SRC];
    logic [CntW-1:0]       cnt_q      [NUM_SRC];

    logic [NUM_SRC-1:0]    src_ready;
    logic [NUM_SRC-1:0]    head_valid;
    logic [NUM_SRC-1:0]    push;
    logic [NUM_SRC-1:0]    grant;
    logic [4:0]            head_addr  [NUM_SRC];
    logic [DATA_WIDTH-1:0] head_data  [NUM_SRC];
    logic                  fifos_empty;

    logic                  slot_vld   [3];
    logic [4:0]            slot_addr  [3];
    logic [DATA_WIDTH-1:0] slot_data  [3];

    logic                  we_q    [3];
    logic [4:0]            waddr_q [3];
    logic [DATA_WIDTH-1:0] wd_q    [3];

`ifdef DEC_WB_ARB_RR_EN
    logic [SrcW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SrcW-1:0] last_src;
`endif

    always_comb begin
        fifos_empty = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            head_valid[i] = (cnt_q[i] != '0);
            src_ready[i]  = (cnt_q[i] != CntW'(FIFO_DEPTH));
            // r0 writes are acknowledged but never stored.
            push[i]       = bus.src_valid[i] & src_ready[i] & (bus.src_waddr[5*i +: 5] != 5'd0);
            head_addr[i]  = addr_mem_q[i][rd_ptr_q[i]];
            head_data[i]  = data_mem_q[i][rd_ptr_q[i]];
            if (head_valid[i]) begin
                fifos_empty = 1'b0;
            end
        end
    end

    always_comb begin : p_select
        logic [SrcW-1:0] s;
        logic [SumW-1:0] idx_sum;
        logic [1:0]      n;
        logic            clash;
        s       = '0;
        idx_sum = '0;
        n       = 2'd0;
        clash   = 1'b0;
        grant   = '0;
        for (int k = 0; k < 3; k++) begin
            slot_vld[k]  = 1'b0;
            slot_addr[k] = '0;
            slot_data[k] = '0;
        end
`ifdef DEC_WB_ARB_RR_EN
        last_src = rr_ptr_q;
`endif
        for (int j = 0; j < NUM_SRC; j++) begin
`ifdef DEC_WB_ARB_RR_EN
            idx_sum = {1'b0, rr_ptr_q} + SumW'(j);
            if (idx_sum >= SumW'(NUM_SRC)) begin
                idx_sum = idx_sum - SumW'(NUM_SRC);
            end
            s = idx_sum[SrcW-1:0];
`else
            s = SrcW'(j);
`endif
            if (head_valid[s] && (n != 2'd3)) begin
                clash = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    if (slot_vld[k] && (slot_addr[k] == head_addr[s])) begin
                        clash = 1'b1;
                    end
                end
                if (!clash) begin
                    grant[s]     = 1'b1;
                    slot_vld[n]  = 1'b1;
                    slot_addr[n] = head_addr[s];
                    slot_data[n] = head_data[s];
                    n            = n + 2'd1;
`ifdef DEC_WB_ARB_RR_EN
                    last_src     = s;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
                end
                if (grant[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
                end
                case ({push[i], grant[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CntW'(1);
                    2'b01:   cnt_q[i] <= cnt_q[i] - CntW'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                addr_mem_q[i][wr_ptr_q[i]] <= bus.src_waddr[5*i +: 5];
                data_mem_q[i][wr_ptr_q[i]] <= bus.src_wdata[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Unused slots carry zero address/data, so the GPR sees clean ports.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst || flush) begin
                we_q[k]    <= 1'b0;
                waddr_q[k] <= '0;
                wd_q[k]    <= '0;
            end else begin
                we_q[k]    <= slot_vld[k];
                waddr_q[k] <= slot_addr[k];
                wd_q[k]    <= slot_data[k];
            end
        end
    end

`ifdef DEC_WB_ARB_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|grant) begin
            rr_ptr_d = (last_src == SrcW'(NUM_SRC - 1)) ? '0 : last_src + SrcW'(1);
        end
    end

    // Survives flush; a flushed cycle's grants never take effect, so the pointer holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (!flush) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign bus.src_ready = src_ready;
    assign bus.we0       = we_q[0];
    assign bus.we1       = we_q[1];
    assign bus.we2       = we_q[2];
    assign bus.waddr0    = waddr_q[0];
    assign bus.waddr1    = waddr_q[1];
    assign bus.waddr2    = waddr_q[2];
    assign bus.wd0       = wd_q[0];
    assign bus.wd1       = wd_q[1];
    assign bus.wd2       = wd_q[2];

    assign idle = fifos_empty & ~(we_q[0] | we_q[1] | we_q[2]);
endmodule
